// File: rtl/serial_comp32.sv
// Nibble-serial magnitude comparator: one 4-bit slice per cycle, LSB first, producing
// eq/lt/gt and an RV32I branch/set-less-than decision behind a valid/ready handshake.
module serial_comp32 #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   funct3,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         eq,
  output logic         lt,
  output logic         gt,
  output logic         taken
);

  localparam int N  = W / 4;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state;
  logic [KW-1:0] k;
  logic [W-1:0]  opa;
  logic [W-1:0]  opb;
  logic [2:0]    op_f3;
  logic          run_eq;
  logic          run_lt;
  logic          run_gt;
  logic          nxt_eq;
  logic          nxt_lt;
  logic          nxt_gt;

  function automatic logic is_signed_op(input logic [2:0] f);
    return (f == 3'b010) || (f == 3'b100) || (f == 3'b101);
  endfunction

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  function automatic logic [W-1:0] bias_msb(input logic [W-1:0] v, input logic sgn);
    return {v[W-1] ^ sgn, v[W-2:0]};
  endfunction

  function automatic logic branch_taken(input logic [2:0] f, input logic e, input logic l);
    case (f)
      3'b000:         return e;
      3'b001:         return ~e;
      3'b101, 3'b111: return ~l;
      default:        return l;
    endcase
  endfunction

  assign in_ready = (state == IDLE) && rst_n;

  // A differing nibble overrides everything below it; an equal one passes the cascade through.
  always_comb begin
    nxt_eq = run_eq;
    nxt_lt = run_lt;
    nxt_gt = run_gt;
    if (opa[3:0] != opb[3:0]) begin
      nxt_eq = 1'b0;
      nxt_lt = opa[3:0] < opb[3:0];
      nxt_gt = opa[3:0] > opb[3:0];
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      opa    <= bias_msb(a, is_signed_op(funct3));
      opb    <= bias_msb(b, is_signed_op(funct3));
      op_f3  <= funct3;
      run_eq <= 1'b1;
      run_lt <= 1'b0;
      run_gt <= 1'b0;
    end else if (state == RUN) begin
      opa    <= opa >> 4;
      opb    <= opb >> 4;
      run_eq <= nxt_eq;
      run_lt <= nxt_lt;
      run_gt <= nxt_gt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      out_valid <= 1'b0;
      eq        <= 1'b0;
      lt        <= 1'b0;
      gt        <= 1'b0;
      taken     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state <= RUN;
            k     <= '0;
          end
        end
        RUN: begin
          k <= k + 1'b1;
          if (k == K_LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
            eq        <= nxt_eq;
            lt        <= nxt_lt;
            gt        <= nxt_gt;
            taken     <= branch_taken(op_f3, nxt_eq, nxt_lt);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_comp32.sv
// Directed-vector bench for serial_comp32 (W=32): latency, compare codes, backpressure, mid-run reset.
module tb_serial_comp32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic [2:0]  funct3;
  logic        out_valid;
  logic        out_ready;
  logic        eq;
  logic        lt;
  logic        gt;
  logic        taken;

  int checks = 0;
  int errors = 0;

  serial_comp32 #(.W(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .funct3(funct3), .out_valid(out_valid), .out_ready(out_ready),
    .eq(eq), .lt(lt), .gt(gt), .taken(taken)
  );

  always #5 clk = ~clk;

  // Handshake one request, then count edges until out_valid (bounded). Called #1 after an edge.
  task automatic issue(input logic [31:0] va, input logic [31:0] vb, input logic [2:0] f,
                       output int lat, output logic rdy);
    a = va; b = vb; funct3 = f; in_valid = 1'b1;
    rdy = in_ready;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~va; b = va ^ vb; funct3 = ~f;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; funct3 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, eq, lt, gt, taken} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000", {out_valid, eq, lt, gt, taken});
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_ready_low got=%b want=0", in_ready);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_in_ready got=%b want=1", in_ready);
    end
    @(posedge clk); #1;
  endtask

  // Eight nibble edges follow the handshake edge, so out_valid shows up in cycle 9.
  task automatic test_beq_latency();
    int   lat;
    logic rdy;
    issue(32'd5, 32'd5, 3'b000, lat, rdy);
    checks++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL beq_in_ready got=%b want=1", rdy); end
    checks++;
    if (lat != 8) begin errors++; $display("FAIL beq_latency edges=%0d want=8", lat); end
    checks++;
    if ({eq, lt, gt, taken} !== 4'b1001) begin
      errors++;
      $display("FAIL beq_flags got=%b want=1001", {eq, lt, gt, taken});
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL beq_release got=%b want=01", {out_valid, in_ready});
    end
  endtask

  // Vectors issued at the minimum initiation interval (next request right after acceptance).
  task automatic test_vectors();
    logic [31:0] ta [8];
    logic [31:0] tb [8];
    logic [2:0]  tf [8];
    logic [3:0]  te [8];
    int   lat;
    logic rdy;
    ta[0] = 32'hFFFFFFFF; tb[0] = 32'h00000001; tf[0] = 3'b100; te[0] = 4'b0101;
    ta[1] = 32'hFFFFFFFF; tb[1] = 32'h00000001; tf[1] = 3'b110; te[1] = 4'b0010;
    ta[2] = 32'h80000000; tb[2] = 32'h7FFFFFFF; tf[2] = 3'b101; te[2] = 4'b0100;
    ta[3] = 32'h80000000; tb[3] = 32'h7FFFFFFF; tf[3] = 3'b111; te[3] = 4'b0011;
    ta[4] = 32'h00000010; tb[4] = 32'h00000001; tf[4] = 3'b011; te[4] = 4'b0010;
    ta[5] = 32'h00000005; tb[5] = 32'h00000006; tf[5] = 3'b001; te[5] = 4'b0101;
    ta[6] = 32'h00000003; tb[6] = 32'hFFFFFFFE; tf[6] = 3'b010; te[6] = 4'b0010;
    ta[7] = 32'h12345678; tb[7] = 32'h12345678; tf[7] = 3'b001; te[7] = 4'b1000;
    for (int i = 0; i < 8; i++) begin
      issue(ta[i], tb[i], tf[i], lat, rdy);
      checks++;
      if (rdy !== 1'b1 || lat != 8) begin
        errors++;
        $display("FAIL vec%0d_timing in_ready=%b edges=%0d want 1/8", i, rdy, lat);
      end
      checks++;
      if ({eq, lt, gt, taken} !== te[i]) begin
        errors++;
        $display("FAIL vec%0d_flags got=%b want=%b", i, {eq, lt, gt, taken}, te[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    int   lat;
    logic rdy;
    out_ready = 1'b0;
    issue(32'h0000ABCD, 32'h0000ABCE, 3'b100, lat, rdy);
    checks++;
    if (lat != 8 || {eq, lt, gt, taken} !== 4'b0101) begin
      errors++;
      $display("FAIL bp_result edges=%0d flags=%b want 8/0101", lat, {eq, lt, gt, taken});
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({out_valid, in_ready, eq, lt, gt, taken} !== 6'b100101) begin
        errors++;
        $display("FAIL bp_hold%0d got=%b want=100101", i, {out_valid, in_ready, eq, lt, gt, taken});
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL bp_release got=%b want=01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid_run();
    int seen = 0;
    a = 32'h00000001; b = 32'h00000002; funct3 = 3'b110; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({out_valid, eq, lt, gt, taken} !== 5'b0) begin
      errors++;
      $display("FAIL midrst_outputs got=%b want=00000", {out_valid, eq, lt, gt, taken});
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst_in_ready got=%b want=1", in_ready);
    end
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL midrst_no_result out_valid_cycles=%0d want=0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_beq_latency();
    test_vectors();
    test_backpressure();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_comp32.md
SERIAL_COMP32 -- requirements
Module: serial_comp32

Interface
REQ-001 SHALL have parameter W, default 32, operand width in bits; legal values are multiples of 4 and at least 8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, request valid.
REQ-005 SHALL have port in_ready, output, 1, block can accept a request.
REQ-006 SHALL have ports a and b, input, W each, the operands.
REQ-007 SHALL have port funct3, input, 3, RV32I compare code: 000 BEQ, 001 BNE, 010 SLT, 011 SLTU, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU.
REQ-008 SHALL have port out_valid, output, 1, result valid.
REQ-009 SHALL have port out_ready, input, 1, consumer accepts the result.
REQ-010 SHALL have ports eq, lt and gt, output, 1 each, a==b, a<b and a>b under the selected signedness.
REQ-011 SHALL have port taken, output, 1, branch-taken or set-less-than result for funct3.

Function
REQ-012 SHALL implement FSM states IDLE, RUN and DONE.
REQ-013 SHALL drive in_ready=1 only in IDLE with rst_n=1; in_ready is 0 in RUN and DONE.
REQ-014 SHALL capture a, b and funct3 on the rising edge where in_valid&in_ready=1, then go IDLE->RUN.
REQ-015 SHALL select signed compare for funct3 010, 100 and 101; all other codes are unsigned.
- For signed compares, bit W-1 of both captured operands is inverted at capture.
REQ-016 SHALL initialise running flags to eq=1, lt=0, gt=0 at capture and clear nibble counter k to 0.
REQ-017 SHALL, in RUN, process one nibble per cycle, LSB first, nibble k = bits [4k+3:4k].
- If the nibbles differ: set lt or gt from the nibble's magnitude relation and clear eq.
- If the nibbles are equal: keep the previous flags (cascade input).
- Then increment k.
REQ-018 SHALL go RUN->DONE on the edge that processes nibble W/4-1, so out_valid first rises W/4+1 cycles after the handshake cycle (9 for W=32).
REQ-019 SHALL compute taken as follows.
- 000: eq.
- 001: ~eq.
- 010, 011, 100, 110: lt.
- 101, 111: ~lt.
REQ-020 SHALL keep out_valid=1 in DONE until out_valid&out_ready on a rising edge, then go DONE->IDLE.
REQ-021 SHALL hold eq, lt, gt and taken stable while out_valid=1 and out_ready=0.
REQ-022 SHALL assert exactly one of eq, lt and gt whenever out_valid=1.
REQ-023 SHALL NOT overlap transactions; minimum initiation interval is W/4+2 cycles.
REQ-024 SHALL drive eq, lt, gt and taken from registers; they may hold the last values outside DONE.
REQ-025 SHALL ignore changes on a, b and funct3 outside the capture edge.

Reset
REQ-026 SHALL, on any rising edge with rst_n=0, set the following.
- State IDLE, k=0.
- out_valid=0, eq=0, lt=0, gt=0, taken=0.
REQ-027 SHALL, when reset hits in RUN or DONE, abandon the transaction: no out_valid for it.
- in_ready=1 on the first cycle after rst_n returns high.

Verification
REQ-028 SHALL cover these directed scenarios.
- a=5, b=5, funct3=000, out_ready=1 -> out_valid in cycle 9 after the handshake, eq=1, lt=0, gt=0, taken=1.
- a=0xFFFFFFFF, b=0x00000001, funct3=100 -> lt=1, taken=1.
- Same operands, funct3=110 -> gt=1, taken=0.
- a=0x80000000, b=0x7FFFFFFF, funct3=101 -> lt=1, taken=0.
- Same operands, funct3=111 -> gt=1, taken=1.
- a=0x00000010, b=0x00000001, funct3=011 -> gt=1, taken=0 (higher nibble overrides lower).
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid and flags stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
- rst_n=0 for one edge when k=3 in RUN -> out_valid=0 and all flags 0 next cycle, in_ready=1 after release, no result emitted.
